// File: rtl/chiptune_apu.sv
// rtl/chiptune_apu.sv - NES-style multi-channel pulse APU with frame sequencer and saturating mixer
// Optional sweep units are built when CHIPTUNE_SWEEP_EN is defined.
module chiptune_apu #(
  parameter int NUM_CH    = 2,
  parameter int DAC_W     = 6,
  parameter int FRAME_DIV = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [1:0]        wr_ch,
  input  logic [1:0]        wr_reg,
  input  logic [7:0]        wr_data,
  output logic [DAC_W-1:0]  dac,
  output logic [NUM_CH-1:0] ch_active
);
  localparam int SUM_W   = 4 + $clog2(NUM_CH) + 1;
  localparam int FC_W    = $clog2(FRAME_DIV + 1);
  localparam int DAC_MAX = (1 << DAC_W) - 1;

  logic [7:0]        ctrl      [NUM_CH];
  logic [10:0]       period    [NUM_CH];
  logic [10:0]       timer     [NUM_CH];
  logic [2:0]        step      [NUM_CH];
  logic [5:0]        length    [NUM_CH];
  logic              env_start [NUM_CH];
  logic [3:0]        env_div   [NUM_CH];
  logic [3:0]        decay     [NUM_CH];
  logic [3:0]        ch_val    [NUM_CH];
  logic [NUM_CH-1:0] mute;
`ifdef CHIPTUNE_SWEEP_EN
  logic [7:0]        sweep     [NUM_CH];
  logic [2:0]        sw_div    [NUM_CH];
  logic              sw_reload [NUM_CH];
  logic [11:0]       target    [NUM_CH];
`endif

  logic [FC_W-1:0]   frame_cnt;
  logic              half_tgl;
  logic              qtr;
  logic              half;
  logic [SUM_W-1:0]  sum;

  assign qtr  = (frame_cnt == FC_W'(FRAME_DIV - 1));
  assign half = qtr & half_tgl;

  // Step 0 is the leftmost (MSB) entry of each pattern.
  function automatic logic duty_bit(input logic [1:0] duty, input logic [2:0] idx);
    logic [7:0] pat;
    case (duty)
      2'd0:    pat = 8'b0100_0000;
      2'd1:    pat = 8'b0110_0000;
      2'd2:    pat = 8'b0111_1000;
      default: pat = 8'b1001_1111;
    endcase
    return pat[3'd7 - idx];
  endfunction

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef CHIPTUNE_SWEEP_EN
      // Negate is ones'-complement, matching the first pulse channel of the original part.
      target[i] = sweep[i][3]
                ? {1'b0, period[i]} - ({1'b0, period[i]} >> sweep[i][2:0]) - 12'd1
                : {1'b0, period[i]} + ({1'b0, period[i]} >> sweep[i][2:0]);
      mute[i]   = (target[i] > 12'h7FF) || (period[i] < 11'd8);
`else
      mute[i]   = (period[i] < 11'd8);
`endif
      ch_val[i] = '0;
      if (duty_bit(ctrl[i][7:6], step[i]) && (length[i] != 6'd0) && !mute[i])
        ch_val[i] = ctrl[i][4] ? ctrl[i][3:0] : decay[i];
      sum = sum + SUM_W'(ch_val[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      half_tgl  <= 1'b0;
      dac       <= '0;
      ch_active <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        ctrl[i]      <= '0;
        period[i]    <= '0;
        timer[i]     <= '0;
        step[i]      <= '0;
        length[i]    <= '0;
        env_start[i] <= 1'b0;
        env_div[i]   <= '0;
        decay[i]     <= '0;
`ifdef CHIPTUNE_SWEEP_EN
        sweep[i]     <= '0;
        sw_div[i]    <= '0;
        sw_reload[i] <= 1'b0;
`endif
      end
    end else begin
      frame_cnt <= qtr ? '0 : frame_cnt + FC_W'(1);
      if (qtr)
        half_tgl <= ~half_tgl;

      for (int i = 0; i < NUM_CH; i++) begin
        if (timer[i] == 11'd0) begin
          timer[i] <= period[i];
          step[i]  <= step[i] + 3'd1;
        end else begin
          timer[i] <= timer[i] - 11'd1;
        end

        if (qtr) begin
          if (env_start[i]) begin
            decay[i]     <= 4'd15;
            env_div[i]   <= ctrl[i][3:0];
            env_start[i] <= 1'b0;
          end else if (env_div[i] == 4'd0) begin
            env_div[i] <= ctrl[i][3:0];
            if (decay[i] != 4'd0)
              decay[i] <= decay[i] - 4'd1;
            else if (ctrl[i][5])
              decay[i] <= 4'd15;
          end else begin
            env_div[i] <= env_div[i] - 4'd1;
          end
        end

        if (half && (length[i] != 6'd0) && !ctrl[i][5])
          length[i] <= length[i] - 6'd1;

`ifdef CHIPTUNE_SWEEP_EN
        if (half) begin
          if ((sw_div[i] == 3'd0) && sweep[i][7] && (sweep[i][2:0] != 3'd0) && !mute[i])
            period[i] <= target[i][10:0];
          if ((sw_div[i] == 3'd0) || sw_reload[i]) begin
            sw_div[i]    <= sweep[i][6:4];
            sw_reload[i] <= 1'b0;
          end else begin
            sw_div[i] <= sw_div[i] - 3'd1;
          end
        end
`endif

        // Register writes come last so a reload beats any tick on the same edge.
        if (wr_en && (int'(wr_ch) == i)) begin
          case (wr_reg)
            2'd0: ctrl[i] <= wr_data;
            2'd1: begin
`ifdef CHIPTUNE_SWEEP_EN
              sweep[i]     <= wr_data;
              sw_reload[i] <= 1'b1;
`endif
            end
            2'd2: period[i][7:0] <= wr_data;
            default: begin
              period[i][10:8] <= wr_data[2:0];
              length[i]       <= {wr_data[7:3], 1'b1};
              step[i]         <= 3'd0;
              timer[i]        <= {wr_data[2:0], period[i][7:0]};
              env_start[i]    <= 1'b1;
            end
          endcase
        end

        ch_active[i] <= (length[i] != 6'd0);
      end

      dac <= (int'(sum) > DAC_MAX) ? DAC_W'(DAC_MAX) : DAC_W'(sum);
    end
  end
endmodule

// File: tb/tb_chiptune_apu.sv
// tb/tb_chiptune_apu.sv - randomized self-checking bench for chiptune_apu
// Expected output is computed in closed form from write times and frame tick counts.
module tb_chiptune_apu;
  localparam int NUM_CH = 2;
  localparam int DAC_W  = 6;
  localparam int FD     = 20;
  localparam int DMAX   = (1 << DAC_W) - 1;
  localparam logic [7:0] DUTY [4] = '{8'b0100_0000, 8'b0110_0000, 8'b0111_1000, 8'b1001_1111};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_ch = '0;
  logic [1:0]        wr_reg = '0;
  logic [7:0]        wr_data = '0;
  logic [DAC_W-1:0]  dac;
  logic [NUM_CH-1:0] ch_active;

  logic              w4_en = 1'b0;
  logic [1:0]        w4_ch = '0;
  logic [1:0]        w4_reg = '0;
  logic [7:0]        w4_data = '0;
  logic [4:0]        dac4;
  logic [3:0]        ch_active4;

  chiptune_apu #(.NUM_CH(NUM_CH), .DAC_W(DAC_W), .FRAME_DIV(FD)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_reg(wr_reg),
    .wr_data(wr_data), .dac(dac), .ch_active(ch_active)
  );

  chiptune_apu #(.NUM_CH(4), .DAC_W(5), .FRAME_DIV(FD)) dut4 (
    .clk(clk), .rst(rst), .wr_en(w4_en), .wr_ch(w4_ch), .wr_reg(w4_reg),
    .wr_data(w4_data), .dac(dac4), .ch_active(ch_active4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_edge = 0;
  int chk_from = 0;
  int peak = 0;
  int peak4 = 0;

  bit         loaded [NUM_CH];
  int         t0     [NUM_CH];
  int         per    [NUM_CH];
  logic [7:0] r0m    [NUM_CH];
  int         len0   [NUM_CH];

  bit         cfg_on  [NUM_CH];
  logic [7:0] cfg_r0  [NUM_CH];
  int         cfg_per [NUM_CH];
  int         cfg_idx [NUM_CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Ticks of period div (counted from reset) on edges in (a, b].
  function automatic int ticks(input int a, input int b, input int div);
    return (b - rst_edge) / div - (a - rst_edge) / div;
  endfunction

  function automatic int model_len(input int c, input int s);
    int h;
    if (!loaded[c]) return 0;
    if (r0m[c][5]) return len0[c];
    h = ticks(t0[c], s, 2 * FD);
    return (h >= len0[c]) ? 0 : len0[c] - h;
  endfunction

  function automatic int model_val(input int c, input int s);
    int stp, q, d, ep, vol;
    if (model_len(c, s) == 0 || per[c] < 8) return 0;
    stp = ((s - t0[c]) / (per[c] + 1)) % 8;
    if (!DUTY[r0m[c][7:6]][7 - stp]) return 0;
    if (r0m[c][4]) return int'(r0m[c][3:0]);
    q  = ticks(t0[c], s, FD);
    if (q == 0) return 0;
    ep = int'(r0m[c][3:0]);
    d  = (q - 1) / (ep + 1);
    if (r0m[c][5]) vol = 15 - (d % 16);
    else           vol = (d >= 15) ? 0 : 15 - d;
    return vol;
  endfunction

  task automatic tick();
    bit was_rst = rst;
    int tot, act;
    @(posedge clk);
    cyc++;
    if (was_rst) begin
      rst_edge = cyc;
      for (int c = 0; c < NUM_CH; c++) loaded[c] = 0;
    end
    #1;
    if (was_rst) begin
      check("rst_dac", dac, 0);
      check("rst_active", ch_active, 0);
    end else begin
      if (int'(dac4) > peak4) peak4 = int'(dac4);
      if (cyc >= chk_from) begin
        tot = 0;
        act = 0;
        for (int c = 0; c < NUM_CH; c++) begin
          tot += model_val(c, cyc - 1);
          if (model_len(c, cyc - 1) != 0) act |= (1 << c);
        end
        check("dac", dac, (tot > DMAX) ? DMAX : tot);
        check("ch_active", ch_active, act);
        if (int'(dac) > peak) peak = int'(dac);
      end
    end
  endtask

  task automatic wr(input int ch, input int rg, input int data);
    wr_ch   = 2'(ch);
    wr_reg  = 2'(rg);
    wr_data = 8'(data);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wr4(input int ch, input int rg, input int data);
    w4_ch   = 2'(ch);
    w4_reg  = 2'(rg);
    w4_data = 8'(data);
    w4_en   = 1'b1;
    tick();
    w4_en   = 1'b0;
  endtask

  // Places every write of a batch just before a quarter tick, so no tick sees a half-programmed channel.
  task automatic run_batch();
    int nw = 2;
    for (int c = 0; c < NUM_CH; c++) if (cfg_on[c]) nw += 3;
    while (((cyc - rst_edge) % FD) != FD - nw - 1) tick();
    chk_from = cyc + nw + 2;
    wr($urandom_range(NUM_CH, 3), $urandom_range(0, 3), $urandom_range(0, 255));
`ifdef CHIPTUNE_SWEEP_EN
    wr($urandom_range(NUM_CH, 3), 1, $urandom_range(0, 255));
`else
    wr($urandom_range(0, NUM_CH - 1), 1, $urandom_range(0, 255));
`endif
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_on[c]) begin
        wr(c, 0, int'(cfg_r0[c]));
        wr(c, 2, cfg_per[c] & 255);
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_on[c]) begin
        wr(c, 3, (cfg_idx[c] << 3) | (cfg_per[c] >> 8));
        loaded[c] = 1;
        t0[c]     = cyc;
        per[c]    = cfg_per[c];
        r0m[c]    = cfg_r0[c];
        len0[c]   = cfg_idx[c] * 2 + 1;
      end
    end
  endtask

  task automatic set_cfg(input int c, input bit on, input int r0, input int p, input int idx);
    cfg_on[c]  = on;
    cfg_r0[c]  = 8'(r0);
    cfg_per[c] = p;
    cfg_idx[c] = idx;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    repeat (25) tick();
    check("idle_dac", dac, 0);

    // Basic tone on both channels mixes to a peak of 30.
    set_cfg(0, 1, 8'hBF, 8, 31);
    set_cfg(1, 1, 8'hBF, 8, 31);
    run_batch();
    peak = 0;
    repeat (200) tick();
    check("mix_peak", peak, 30);
    check("tone_active", ch_active, 3);

    // Four channels into a 5-bit DAC saturate at 31.
    peak4 = 0;
    for (int c = 0; c < 4; c++) begin
      wr4(c, 0, 8'hBF);
      wr4(c, 2, 8'h08);
      wr4(c, 3, 8'hF8);
    end
    repeat (150) tick();
    check("clamp_peak", peak4, 31);
    check("clamp_active", ch_active4, 4'hF);

    // Reset mid-tone, then a length-1 note that expires on the first half tick.
    do_reset();
    set_cfg(0, 1, 8'h9F, 8, 0);
    set_cfg(1, 0, 0, 8, 0);
    run_batch();
    while (cyc < rst_edge + 40) tick();
    check("len_before", ch_active[0], 1);
    tick();
    check("len_after", ch_active[0], 0);
    check("len_after_dac", dac, 0);

    // Period below 8 is muted; a non-looping envelope decays to zero.
    set_cfg(0, 1, 8'hBF, 5, 31);
    set_cfg(1, 1, 8'h83, 8, 31);
    run_batch();
    repeat (1400) tick();
    check("env_end_dac", dac, 0);
    check("env_end_active", ch_active, 3);

    for (int b = 0; b < 12; b++) begin
      for (int c = 0; c < NUM_CH; c++)
        set_cfg(c, $urandom_range(0, 3) != 0, $urandom_range(0, 255),
                ($urandom_range(0, 9) < 6) ? $urandom_range(3, 40) : $urandom_range(41, 1023),
                $urandom_range(0, 31));
      run_batch();
      repeat ($urandom_range(100, 500)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
